// File: rtl/iddmm_driver.sv
// ============================================================================
// iddmm_driver
// ----------------------------------------------------------------------------
// Host-side initiator for one IDDMM Montgomery multiplier instance.
//
// A job arrives as N beats of K-bit x/y/m words, least-significant word first.
// Each beat is copied into the multiplier operand RAMs through a registered
// write port. After the last write, the driver raises a task request. It then
// collects the N-word result into a local buffer. The buffer is replayed on a
// valid/ready stream, so downstream stalls never reach the multiplier.
//
// Parameters:
//   K        bits per word
//   N        words per operand
//   ADDR_W   word address width
//   TIMEOUT  grant-wait limit in cycles (timeout build only)
//
// Ports:
//   clk, rst                   single clock; synchronous active-high reset
//   in_valid / in_ready        operand beat handshake
//   in_x, in_y, in_m           operand words for the current beat
//   in_mask                    RAM write mask {m,y,x}; sampled on word 0
//   in_m1                      -m^-1 mod 2^K; sampled on word 0
//   wr_ena, wr_addr            multiplier write strobe and word address
//   wr_x, wr_y, wr_m, wr_m1    multiplier write data
//   task_req                   task request to the multiplier
//   task_grant, task_end       result word strobe, and last-word marker
//   task_res                   result word
//   m_valid / m_ready          result stream handshake
//   m_data, m_last             result stream payload
//   busy                       FSM is not idle
//   err                        one-cycle error pulse
//
// Optional feature:
//   Define IDDMM_DRV_TIMEOUT_EN to abandon a request that sees no grant
//   within TIMEOUT cycles. Without it, REQ waits indefinitely.
// ============================================================================
module iddmm_driver #(
    parameter int K       = 128,
    parameter int N       = 32,
    parameter int ADDR_W  = $clog2(N),
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [K-1:0]      in_x,
    input  logic [K-1:0]      in_y,
    input  logic [K-1:0]      in_m,
    input  logic [2:0]        in_mask,
    input  logic [K-1:0]      in_m1,
    output logic [2:0]        wr_ena,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [K-1:0]      wr_x,
    output logic [K-1:0]      wr_y,
    output logic [K-1:0]      wr_m,
    output logic [K-1:0]      wr_m1,
    output logic              task_req,
    input  logic              task_grant,
    input  logic              task_end,
    input  logic [K-1:0]      task_res,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [K-1:0]      m_data,
    output logic              m_last,
    output logic              busy,
    output logic              err
);

    // Counters carry one extra bit so that the value N is representable.
    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        REQ,
        COLLECT,
        DRAIN
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] rd_idx;
    logic [2:0]       mask_q;
    logic [K-1:0]     m1_q;
    logic             req_q;
    logic             ovf_flag;
    logic [K-1:0]     res_buf [N];

    logic [CNT_W-1:0] beat_idx;
    logic [CNT_W-1:0] word_cnt_next;
    logic [2:0]       mask_eff;
    logic             accept;
    logic             last_beat;
    logic             grant_take;
    logic             store;
    logic             overflow;
    logic             end_evt;
    logic             drain_step;
    logic             req_next;
    logic             err_next;
    logic             timeout;

    // An all-zero mask would load nothing, so it is treated as a full load.
    assign mask_eff = (in_mask == 3'b000) ? 3'b111 : in_mask;

    assign in_ready = !rst && ((state == IDLE) || (state == LOAD));
    assign busy     = (state != IDLE);
    // The request drops in the same cycle as the first grant.
    assign task_req = req_q && !task_grant;
    assign m_valid  = (state == DRAIN);
    assign m_data   = m_valid ? res_buf[rd_idx[ADDR_W-1:0]] : '0;
    assign m_last   = m_valid && ((rd_idx + ONE_CNT) == word_cnt);
    assign wr_m1    = busy ? m1_q : '0;

`ifdef IDDMM_DRV_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;

    // Count the cycles in which the request is visible and still not granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if ((state == REQ) && req_q && !task_grant) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout = (state == REQ) && req_q && !task_grant &&
                     (to_cnt == TO_W'(TIMEOUT - 1));
`else
    // No grant limit in this build; the term folds to constant zero.
    assign timeout = 1'b0 && (TIMEOUT > 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_next    = state;
        req_next      = 1'b0;
        err_next      = 1'b0;
        beat_idx      = (state == LOAD) ? beat_cnt : '0;
        accept        = in_valid && in_ready;
        last_beat     = (beat_idx == LAST_IDX);
        grant_take    = task_grant && ((state == REQ) || (state == COLLECT));
        store         = grant_take && (word_cnt < N_CNT);
        overflow      = grant_take && (word_cnt >= N_CNT);
        word_cnt_next = word_cnt + (store ? ONE_CNT : '0);
        end_evt       = task_end && ((state == COLLECT) ||
                                     ((state == REQ) && task_grant));
        drain_step    = m_valid && m_ready;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = last_beat ? REQ : LOAD;
                end
                if (task_grant) begin
                    err_next = 1'b1;
                end
            end
            LOAD: begin
                if (accept && last_beat) begin
                    state_next = REQ;
                end
                if (task_grant) begin
                    err_next = 1'b1;
                end
            end
            REQ: begin
                // The request is raised one cycle after entry, so it follows
                // the final operand write.
                if (timeout) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else if (task_grant) begin
                    state_next = end_evt ? DRAIN : COLLECT;
                end else begin
                    req_next = 1'b1;
                end
            end
            COLLECT: begin
                if (end_evt) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_step && m_last) begin
                    state_next = IDLE;
                end
                if (task_grant) begin
                    err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Excess result words are flagged only on their first occurrence.
        if (overflow && !ovf_flag) begin
            err_next = 1'b1;
        end
        if (end_evt && (word_cnt_next != N_CNT)) begin
            err_next = 1'b1;
        end
    end

    // Operand write port, job registers, counters and the error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ena   <= '0;
            wr_addr  <= '0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_m     <= '0;
            beat_cnt <= '0;
            word_cnt <= '0;
            rd_idx   <= '0;
            mask_q   <= '0;
            m1_q     <= '0;
            req_q    <= 1'b0;
            ovf_flag <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_ena <= '0;
            err    <= err_next;
            req_q  <= req_next;

            if (accept) begin
                wr_ena   <= (state == IDLE) ? mask_eff : mask_q;
                wr_addr  <= beat_idx[ADDR_W-1:0];
                wr_x     <= in_x;
                wr_y     <= in_y;
                wr_m     <= in_m;
                beat_cnt <= beat_idx + ONE_CNT;
            end

            if (state == IDLE) begin
                word_cnt <= '0;
                rd_idx   <= '0;
                ovf_flag <= 1'b0;
                if (accept) begin
                    mask_q <= mask_eff;
                    m1_q   <= in_m1;
                end
            end

            if (store) begin
                word_cnt <= word_cnt_next;
            end
            if (overflow) begin
                ovf_flag <= 1'b1;
            end
            if (drain_step) begin
                rd_idx <= rd_idx + ONE_CNT;
            end
        end
    end

    // Result buffer; stale contents are never visible because m_data is gated
    always_ff @(posedge clk) begin
        if (store) begin
            res_buf[word_cnt[ADDR_W-1:0]] <= task_res;
        end
    end

endmodule

// File: tb/tb_iddmm_driver.sv
// ============================================================================
// tb_iddmm_driver
// ----------------------------------------------------------------------------
// Directed bench for iddmm_driver with K=16, N=4 and TIMEOUT=16. A negedge
// monitor logs the write port, request edges, error pulses and stream
// handshakes. Each test task drives one scenario and compares the logs
// against hand-computed values.
// ============================================================================
module tb_iddmm_driver;

    localparam int K = 16;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [K-1:0]  in_x, in_y, in_m, in_m1;
    logic [2:0]    in_mask;
    logic [2:0]    wr_ena;
    logic [1:0]    wr_addr;
    logic [K-1:0]  wr_x, wr_y, wr_m, wr_m1;
    logic          task_req, task_grant, task_end;
    logic [K-1:0]  task_res;
    logic          m_valid, m_ready, m_last, busy, err;
    logic [K-1:0]  m_data;

    int n_compared = 0;
    int n_mismatched = 0;

    // Monitor state
    int            cyc = 0;
    logic [2:0]    log_ena[$];
    logic [1:0]    log_addr[$];
    logic [K-1:0]  log_x[$], log_y[$], log_m[$], log_m1[$];
    int            log_wcyc[$];
    logic [K-1:0]  out_data[$];
    logic          out_last[$];
    int            accept0_cyc, req_rise_cyc, req_fall_cyc, err_count, valid_seen;
    logic          req_prev = 1'b0;
    logic          chk_after_last = 1'b0;
    logic          busy_after_last;

    iddmm_driver #(.K(K), .N(N), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_m(in_m),
        .in_mask(in_mask), .in_m1(in_m1),
        .wr_ena(wr_ena), .wr_addr(wr_addr),
        .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1),
        .task_req(task_req), .task_grant(task_grant),
        .task_end(task_end), .task_res(task_res),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_last(m_last),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_ena != 3'b000) begin
                log_ena.push_back(wr_ena);
                log_addr.push_back(wr_addr);
                log_x.push_back(wr_x);
                log_y.push_back(wr_y);
                log_m.push_back(wr_m);
                log_m1.push_back(wr_m1);
                log_wcyc.push_back(cyc);
            end
            if (in_valid && in_ready && !busy) accept0_cyc = cyc;
            if (task_req && !req_prev) req_rise_cyc = cyc;
            if (!task_req && req_prev) req_fall_cyc = cyc;
            if (err) err_count++;
            if (m_valid) valid_seen++;
            if (chk_after_last) begin
                busy_after_last = busy;
                chk_after_last = 1'b0;
            end
            if (m_valid && m_ready) begin
                out_data.push_back(m_data);
                out_last.push_back(m_last);
                if (m_last) chk_after_last = 1'b1;
            end
        end
        req_prev = task_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_ena.delete(); log_addr.delete(); log_x.delete(); log_y.delete();
        log_m.delete(); log_m1.delete(); log_wcyc.delete();
        out_data.delete(); out_last.delete();
        accept0_cyc = -100; req_rise_cyc = -1; req_fall_cyc = -1;
        err_count = 0; valid_seen = 0; busy_after_last = 1'b1;
    endtask

    // Presents four beats; word i of each operand is {xs,ys,ms}[16*i +: 16].
    task automatic load_job(input logic [2:0] mask, input logic [K-1:0] m1,
                            input logic [63:0] xs, input logic [63:0] ys,
                            input logic [63:0] ms);
        in_mask = mask;
        in_m1 = m1;
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_x = xs[16*i +: 16];
            in_y = ys[16*i +: 16];
            in_m = ms[16*i +: 16];
            step();
        end
        in_valid = 1'b0;
        in_mask = 3'b000;
        in_m1 = '0;
    endtask

    // Multiplier model: waits for the request, then returns n words.
    task automatic grant_words(input int n, input logic [K-1:0] base);
        int guard = 0;
        while (!task_req && guard < 100) begin
            step();
            guard++;
        end
        n_compared++;
        if (!task_req) begin
            n_mismatched++;
            $display("[TB] FAIL req_wait: task_req=%0b required 1 within 100 cycles", task_req);
        end
        step();
        for (int i = 0; i < n; i++) begin
            task_grant = 1'b1;
            task_res = base + K'(i);
            task_end = (i == n - 1);
            step();
        end
        task_grant = 1'b0;
        task_end = 1'b0;
        task_res = '0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 200) begin
            step();
            guard++;
        end
        n_compared++;
        if (busy) begin
            n_mismatched++;
            $display("[TB] FAIL idle_wait: busy=%0b required 0 within 200 cycles", busy);
        end
        step();
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0; in_x = '0; in_y = '0; in_m = '0; in_mask = '0; in_m1 = '0;
        task_grant = 1'b0; task_end = 1'b0; task_res = '0; m_ready = 1'b0;
        step();
        step();
        n_compared++;
        if ({in_ready, wr_ena, wr_addr, task_req, m_valid, m_last, busy, err} !== 12'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b required all zero",
                     {in_ready, wr_ena, wr_addr, task_req, m_valid, m_last, busy, err});
        end
        n_compared++;
        if ({wr_x, wr_y, wr_m, wr_m1, m_data} !== 80'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_data: got %h required 0", {wr_x, wr_y, wr_m, wr_m1, m_data});
        end
        rst = 1'b0;
        #1;
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_basic_job();
        clear_logs();
        m_ready = 1'b1;
        load_job(3'b111, 16'h1234, {16'd4, 16'd3, 16'd2, 16'd1},
                 {16'd8, 16'd7, 16'd6, 16'd5}, {16'd12, 16'd11, 16'd10, 16'd9});
        grant_words(4, 16'h00A0);
        wait_idle();
        n_compared++;
        if (log_ena.size() !== 4) begin
            n_mismatched++;
            $display("[TB] FAIL basic_wr_count: got %0d required 4", log_ena.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_compared++;
                if ({log_ena[i], log_addr[i], log_x[i], log_y[i], log_m[i], log_m1[i]} !==
                    {3'b111, 2'(i), 16'(i + 1), 16'(i + 5), 16'(i + 9), 16'h1234}) begin
                    n_mismatched++;
                    $display("[TB] FAIL basic_write%0d: got ena=%b addr=%0d x=%0h y=%0h m=%0h m1=%0h required ena=111 addr=%0d x=%0h y=%0h m=%0h m1=1234",
                             i, log_ena[i], log_addr[i], log_x[i], log_y[i], log_m[i], log_m1[i],
                             i, i + 1, i + 5, i + 9);
                end
                n_compared++;
                if (log_wcyc[i] - accept0_cyc !== i + 1) begin
                    n_mismatched++;
                    $display("[TB] FAIL basic_write%0d_latency: got %0d required %0d",
                             i, log_wcyc[i] - accept0_cyc, i + 1);
                end
            end
            n_compared++;
            if (req_rise_cyc - log_wcyc[3] !== 1) begin
                n_mismatched++;
                $display("[TB] FAIL req_after_last_write: got %0d required 1", req_rise_cyc - log_wcyc[3]);
            end
        end
        n_compared++;
        if (req_rise_cyc - accept0_cyc !== N + 1) begin
            n_mismatched++;
            $display("[TB] FAIL req_latency: got %0d required %0d", req_rise_cyc - accept0_cyc, N + 1);
        end
        n_compared++;
        if (out_data.size() !== 4) begin
            n_mismatched++;
            $display("[TB] FAIL basic_out_count: got %0d required 4", out_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_compared++;
                if ({out_data[i], out_last[i]} !== {16'h00A0 + 16'(i), (i == 3)}) begin
                    n_mismatched++;
                    $display("[TB] FAIL basic_out%0d: got data=%0h last=%b required data=%0h last=%b",
                             i, out_data[i], out_last[i], 16'h00A0 + 16'(i), (i == 3));
                end
            end
        end
        n_compared++;
        if ({busy_after_last, err_count} !== {1'b0, 32'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL basic_end: got busy_after=%b errs=%0d required 0 and 0",
                     busy_after_last, err_count);
        end
    endtask

    task automatic test_stall();
        int guard = 0;
        clear_logs();
        m_ready = 1'b1;
        load_job(3'b111, 16'h1234, {16'd4, 16'd3, 16'd2, 16'd1},
                 {16'd8, 16'd7, 16'd6, 16'd5}, {16'd12, 16'd11, 16'd10, 16'd9});
        grant_words(4, 16'h00A0);
        while (out_data.size() < 2 && guard < 50) begin
            step();
            guard++;
        end
        m_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_compared++;
            if ({m_valid, m_data, m_last} !== {1'b1, 16'h00A2, 1'b0}) begin
                n_mismatched++;
                $display("[TB] FAIL stall_hold%0d: got valid=%b data=%0h last=%b required 1 a2 0",
                         c, m_valid, m_data, m_last);
            end
            step();
        end
        m_ready = 1'b1;
        wait_idle();
        n_compared++;
        if (out_data.size() !== 4) begin
            n_mismatched++;
            $display("[TB] FAIL stall_out_count: got %0d required 4", out_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_compared++;
                if ({out_data[i], out_last[i]} !== {16'h00A0 + 16'(i), (i == 3)}) begin
                    n_mismatched++;
                    $display("[TB] FAIL stall_out%0d: got data=%0h last=%b required data=%0h last=%b",
                             i, out_data[i], out_last[i], 16'h00A0 + 16'(i), (i == 3));
                end
            end
        end
    endtask

    task automatic test_mask();
        logic [2:0] masks [2];
        logic [2:0] expect_ena [2];
        masks[0] = 3'b011; expect_ena[0] = 3'b011;
        masks[1] = 3'b000; expect_ena[1] = 3'b111;
        m_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            clear_logs();
            load_job(masks[j], 16'h0055, 64'h0004_0003_0002_0001,
                     64'h0008_0007_0006_0005, 64'h000C_000B_000A_0009);
            grant_words(4, 16'h00C0);
            wait_idle();
            n_compared++;
            if (log_ena.size() !== 4) begin
                n_mismatched++;
                $display("[TB] FAIL mask%0d_wr_count: got %0d required 4", j, log_ena.size());
            end else begin
                for (int i = 0; i < 4; i++) begin
                    n_compared++;
                    if (log_ena[i] !== expect_ena[j]) begin
                        n_mismatched++;
                        $display("[TB] FAIL mask%0d_ena%0d: got %b required %b",
                                 j, i, log_ena[i], expect_ena[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_short_result();
        clear_logs();
        m_ready = 1'b1;
        load_job(3'b111, 16'h0777, 64'h1, 64'h2, 64'h3);
        grant_words(2, 16'h00B0);
        wait_idle();
        n_compared++;
        if (err_count !== 1) begin
            n_mismatched++;
            $display("[TB] FAIL short_err: got %0d pulses required 1", err_count);
        end
        n_compared++;
        if (out_data.size() !== 2) begin
            n_mismatched++;
            $display("[TB] FAIL short_out_count: got %0d required 2", out_data.size());
        end else begin
            n_compared++;
            if ({out_data[0], out_last[0], out_data[1], out_last[1]} !==
                {16'h00B0, 1'b0, 16'h00B1, 1'b1}) begin
                n_mismatched++;
                $display("[TB] FAIL short_out: got %0h/%b %0h/%b required b0/0 b1/1",
                         out_data[0], out_last[0], out_data[1], out_last[1]);
            end
        end
    endtask

    task automatic test_stray_grant();
        clear_logs();
        task_grant = 1'b1;
        task_res = 16'h00FF;
        step();
        task_grant = 1'b0;
        task_res = '0;
        step();
        step();
        n_compared++;
        if ({err_count, busy, valid_seen} !== {32'd1, 1'b0, 32'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL stray_grant: got errs=%0d busy=%b valid=%0d required 1 0 0",
                     err_count, busy, valid_seen);
        end
    endtask

    task automatic test_timeout();
        clear_logs();
        m_ready = 1'b1;
        load_job(3'b111, 16'h0101, 64'h1, 64'h2, 64'h3);
`ifdef IDDMM_DRV_TIMEOUT_EN
        wait_idle();
        n_compared++;
        if (req_fall_cyc - req_rise_cyc !== 16) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_len: got %0d required 16", req_fall_cyc - req_rise_cyc);
        end
        n_compared++;
        if ({err_count, valid_seen} !== {32'd1, 32'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_err: got errs=%0d valid=%0d required 1 0", err_count, valid_seen);
        end
`else
        for (int c = 0; c < 40; c++) step();
        n_compared++;
        if ({task_req, busy, err_count} !== {1'b1, 1'b1, 32'd0}) begin
            n_mismatched++;
            $display("[TB] FAIL req_hold: got req=%b busy=%b errs=%0d required 1 1 0",
                     task_req, busy, err_count);
        end
        rst = 1'b1;
        step();
        n_compared++;
        if ({busy, task_req, m_valid, in_ready} !== 4'b0000) begin
            n_mismatched++;
            $display("[TB] FAIL midjob_reset: got busy=%b req=%b valid=%b rdy=%b required 0000",
                     busy, task_req, m_valid, in_ready);
        end
        rst = 1'b0;
        step();
`endif
    endtask

    task automatic test_back_to_back();
        clear_logs();
        m_ready = 1'b1;
        load_job(3'b101, 16'h0202, 64'h0040_0030_0020_0010, 64'h5, 64'h6);
        grant_words(4, 16'h00D0);
        wait_idle();
        n_compared++;
        if (out_data.size() !== 4) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_out_count: got %0d required 4", out_data.size());
        end else begin
            n_compared++;
            if ({out_data[0], out_data[1], out_data[2], out_data[3], out_last[3]} !==
                {16'h00D0, 16'h00D1, 16'h00D2, 16'h00D3, 1'b1}) begin
                n_mismatched++;
                $display("[TB] FAIL b2b_out: got %0h %0h %0h %0h last=%b required d0 d1 d2 d3 1",
                         out_data[0], out_data[1], out_data[2], out_data[3], out_last[3]);
            end
        end
        n_compared++;
        if (log_ena.size() !== 4 || log_ena[0] !== 3'b101 || log_x[3] !== 16'h0040) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_writes: got count=%0d required 4 writes, ena 101, x3 40",
                     log_ena.size());
        end
    endtask

    initial begin
        $display("[TB] iddmm_driver bench start");
        test_reset();
        test_basic_job();
        test_stall();
        test_mask();
        test_short_result();
        test_stray_grant();
        test_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
